// File: rtl/m_pipeline_pkg.sv
// -----------------------------------------------------------------------------
// m_pipeline_pkg
// Shared pipeline definitions for the fetch and decode stages.
//   XLEN        : datapath width (32).
//   NOP         : canonical no-op instruction word (addi x0, x0, 0).
//   fetch_pkt_t : {pc, instr} pair carried from fetch into decode.
// -----------------------------------------------------------------------------
package m_pipeline_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;

endpackage : m_pipeline_pkg

// File: rtl/m_if_id_buffer_if.sv
// -----------------------------------------------------------------------------
// m_if_id_buffer_if
// Signal bundle between fetch, the IF/ID buffer and decode.
//   Fetch side  : in_valid, pc_in, instruction_in -> buffer; in_ready <- buffer
//   Decode side : out_valid, pc_out, instruction_out <- buffer; out_ready -> buffer
//   Control     : flush, panic -> buffer; occupancy <- buffer
// Modports:
//   slave  : the buffer itself.
//   master : the surrounding pipeline (fetch, decode, hazard control).
// -----------------------------------------------------------------------------
interface m_if_id_buffer_if #(
    parameter int DEPTH = 2
);
    import m_pipeline_pkg::*;

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic [XLEN-1:0]  pc_in;
    logic [XLEN-1:0]  instruction_in;
    logic             in_ready;

    logic             out_valid;
    logic [XLEN-1:0]  pc_out;
    logic [XLEN-1:0]  instruction_out;
    logic             out_ready;

    logic             flush;
    logic             panic;
    logic [OCC_W-1:0] occupancy;

    modport slave (
        input  in_valid, pc_in, instruction_in, out_ready, flush, panic,
        output in_ready, out_valid, pc_out, instruction_out, occupancy
    );

    modport master (
        output in_valid, pc_in, instruction_in, out_ready, flush, panic,
        input  in_ready, out_valid, pc_out, instruction_out, occupancy
    );

endinterface : m_if_id_buffer_if

// File: rtl/m_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// m_fifo_ctrl
// Pointer/count controller for a small circular buffer with flush.
// DEPTH must be a power of two, at least 2, so pointers wrap by overflow.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   in_valid    : producer offers an entry
//   out_ready   : consumer takes the head entry
//   flush/panic : discard all entries; both also block input this cycle
//   in_ready    : room available and not flushing
//   out_valid   : at least one entry held
//   enq         : an entry is written at wr_ptr this cycle
//   wr_ptr      : next write slot
//   rd_ptr      : head slot
//   count       : number of held entries, 0..DEPTH
// -----------------------------------------------------------------------------
module m_fifo_ctrl #(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             out_ready,
    input  logic             flush,
    input  logic             panic,
    output logic             in_ready,
    output logic             out_valid,
    output logic             enq,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic             deq;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_next;

    // in_ready looks only at registered count and the kill inputs, never at
    // out_ready, so a full buffer refuses input even while it drains.
    assign in_ready  = (count < FULL_COUNT) & ~panic & ~flush;
    assign out_valid = (count != '0);
    assign enq       = in_valid & in_ready;
    assign deq       = out_valid & out_ready;

    // NOTE: every output of a combinational block gets a default at the top;
    // any path that leaves one unassigned would infer a latch.
    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        if (flush || panic) begin
            // Kill wins over any handshake in the same cycle.
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (enq) begin
                wr_ptr_next = wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_next = rd_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_next = count + CNT_W'(1);
                2'b01:   count_next = count - CNT_W'(1);
                default: count_next = count;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        !(enq && (count == FULL_COUNT)));

    a_no_underflow : assert property (@(posedge clk) disable iff (reset)
        !(deq && (count == '0)));

endmodule : m_fifo_ctrl

// File: rtl/m_if_id_buffer.sv
// -----------------------------------------------------------------------------
// m_if_id_buffer
// Decoupling buffer between fetch and decode. Holds up to DEPTH {pc, instr}
// pairs, presents the oldest to decode, back-pressures fetch when full and
// drops everything on flush or panic so decode never sees wrong-path code.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous active-high reset
//   bus   : m_if_id_buffer_if.slave (fetch handshake, decode handshake,
//           flush/panic, occupancy)
// Parameters:
//   DEPTH : entries, power of two, at least 2; must match the interface
//   NOP   : instruction word presented while empty
// -----------------------------------------------------------------------------
module m_if_id_buffer
    import m_pipeline_pkg::*;
#(
    parameter int              DEPTH = 2,
    parameter logic [XLEN-1:0] NOP   = m_pipeline_pkg::NOP
) (
    input logic               clk,
    input logic               reset,
    m_if_id_buffer_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             enq;
    logic             out_valid;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    fetch_pkt_t       mem [DEPTH];

    m_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (bus.in_valid),
        .out_ready (bus.out_ready),
        .flush     (bus.flush),
        .panic     (bus.panic),
        .in_ready  (bus.in_ready),
        .out_valid (out_valid),
        .enq       (enq),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count)
    );

    // NOTE: the storage array has no reset; stale slots are never observable
    // because the output mux below masks them whenever out_valid is low.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= '{pc: bus.pc_in, instr: bus.instruction_in};
        end
    end

    always_comb begin
        bus.pc_out          = '0;
        bus.instruction_out = NOP;
        if (out_valid) begin
            bus.pc_out          = mem[rd_ptr].pc;
            bus.instruction_out = mem[rd_ptr].instr;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.occupancy = count;

endmodule : m_if_id_buffer

// File: tb/tb_m_if_id_buffer.sv
// -----------------------------------------------------------------------------
// tb_m_if_id_buffer
// Directed vector table, hand-written async reset sequence and a randomized
// run against a queue model for m_if_id_buffer (DEPTH = 2).
// -----------------------------------------------------------------------------
module tb_m_if_id_buffer;
    import m_pipeline_pkg::*;

    localparam int DEPTH = 2;
    localparam int NVEC  = 25;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    m_if_id_buffer_if #(.DEPTH(DEPTH)) bus ();

    m_if_id_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        logic        pn;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_pc;
        int          e_occ;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] pc, input logic ordy,
                         input logic fl, input logic pn);
        bus.in_valid       = iv;
        bus.pc_in          = pc;
        bus.instruction_in = ins_of(pc);
        bus.out_ready      = ordy;
        bus.flush          = fl;
        bus.panic          = pn;
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] next_pc;
        logic        r_iv, r_or, r_fl, r_pn, e_ir, enq_m, deq_m;
        int          wr_i, rd_i, wr_wraps, rd_wraps;

        //             iv  pc     or  fl  pn  ir  ov  pc_out occ
        // Stream with decode always ready: occupancy stays 1.
        vecs[0]  = '{1, 32'h00, 1, 0, 0, 1, 0, 32'h00, 0};
        vecs[1]  = '{1, 32'h04, 1, 0, 0, 1, 1, 32'h00, 1};
        vecs[2]  = '{1, 32'h08, 1, 0, 0, 1, 1, 32'h04, 1};
        vecs[3]  = '{0, 32'h00, 1, 0, 0, 1, 1, 32'h08, 1};
        vecs[4]  = '{0, 32'h00, 1, 0, 0, 1, 0, 32'h00, 0};
        // Back-pressure: third pair refused until a slot frees.
        vecs[5]  = '{1, 32'h00, 0, 0, 0, 1, 0, 32'h00, 0};
        vecs[6]  = '{1, 32'h04, 0, 0, 0, 1, 1, 32'h00, 1};
        vecs[7]  = '{1, 32'h08, 0, 0, 0, 0, 1, 32'h00, 2};
        vecs[8]  = '{1, 32'h08, 1, 0, 0, 0, 1, 32'h00, 2};
        vecs[9]  = '{1, 32'h08, 1, 0, 0, 1, 1, 32'h04, 1};
        vecs[10] = '{0, 32'h00, 1, 0, 0, 1, 1, 32'h08, 1};
        vecs[11] = '{0, 32'h00, 1, 0, 0, 1, 0, 32'h00, 0};
        // Flush while full with a pair offered: 0x28 must never appear.
        vecs[12] = '{1, 32'h20, 0, 0, 0, 1, 0, 32'h00, 0};
        vecs[13] = '{1, 32'h24, 0, 0, 0, 1, 1, 32'h20, 1};
        vecs[14] = '{1, 32'h28, 0, 1, 0, 0, 1, 32'h20, 2};
        vecs[15] = '{0, 32'h00, 1, 0, 0, 1, 0, 32'h00, 0};
        vecs[16] = '{1, 32'h30, 0, 0, 0, 1, 0, 32'h00, 0};
        vecs[17] = '{0, 32'h00, 1, 0, 0, 1, 1, 32'h30, 1};
        vecs[18] = '{0, 32'h00, 1, 0, 0, 1, 0, 32'h00, 0};
        // Panic held 4 cycles, then a pair is accepted.
        vecs[19] = '{1, 32'h40, 1, 0, 1, 0, 0, 32'h00, 0};
        vecs[20] = '{1, 32'h40, 1, 0, 1, 0, 0, 32'h00, 0};
        vecs[21] = '{1, 32'h40, 1, 0, 1, 0, 0, 32'h00, 0};
        vecs[22] = '{1, 32'h40, 1, 0, 1, 0, 0, 32'h00, 0};
        vecs[23] = '{1, 32'h44, 0, 0, 0, 1, 0, 32'h00, 0};
        vecs[24] = '{0, 32'h00, 0, 0, 0, 1, 1, 32'h44, 1};

        drive(0, 32'h0, 0, 0, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].iv, vecs[i].pc, vecs[i].ordy, vecs[i].fl, vecs[i].pn);
            @(negedge clk);
            check($sformatf("row%0d in_ready", i),  32'(bus.in_ready),  32'(vecs[i].e_ir));
            check($sformatf("row%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
            check($sformatf("row%0d occupancy", i), 32'(bus.occupancy), 32'(vecs[i].e_occ));
            check($sformatf("row%0d pc_out", i),    bus.pc_out,         vecs[i].e_pc);
            check($sformatf("row%0d instr_out", i), bus.instruction_out,
                  vecs[i].e_ov ? ins_of(vecs[i].e_pc) : NOP);
        end

        // Asynchronous reset between edges with one entry held.
        @(posedge clk);
        #2;
        check("pre_reset occupancy", 32'(bus.occupancy), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset out_valid", 32'(bus.out_valid), 32'd0);
        check("async_reset occupancy", 32'(bus.occupancy), 32'd0);
        check("async_reset instr_out", bus.instruction_out, NOP);
        check("async_reset pc_out",    bus.pc_out, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset in_ready", 32'(bus.in_ready), 32'd1);

        // Randomized run against a queue model.
        next_pc  = 32'h1000;
        wr_i     = 0;
        rd_i     = 0;
        wr_wraps = 0;
        rd_wraps = 0;
        r_iv = ($urandom_range(3) != 0);
        r_or = ($urandom_range(4) > 1);
        r_fl = ($urandom_range(63) == 0);
        r_pn = ($urandom_range(127) == 0);
        drive(r_iv, next_pc, r_or, r_fl, r_pn);
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            e_ir = (q.size() < DEPTH) && !r_fl && !r_pn;
            check("rnd in_ready",  32'(bus.in_ready),  32'(e_ir));
            check("rnd out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
            check("rnd occupancy", 32'(bus.occupancy), 32'(q.size()));
            if (q.size() != 0) begin
                check("rnd pc_out",    bus.pc_out, q[0]);
                check("rnd instr_out", bus.instruction_out, ins_of(q[0]));
            end
            enq_m = r_iv && e_ir;
            deq_m = (q.size() != 0) && r_or && !r_fl && !r_pn;
            @(posedge clk);
            if (r_fl || r_pn) begin
                q.delete();
                wr_i = 0;
                rd_i = 0;
            end else begin
                if (deq_m) begin
                    void'(q.pop_front());
                    rd_i = (rd_i + 1) % DEPTH;
                    if (rd_i == 0) rd_wraps++;
                end
                if (enq_m) begin
                    q.push_back(next_pc);
                    wr_i = (wr_i + 1) % DEPTH;
                    if (wr_i == 0) wr_wraps++;
                end
            end
            if (enq_m || (r_iv && (r_fl || r_pn))) next_pc = next_pc + 32'd4;
            #1;
            r_iv = ($urandom_range(3) != 0);
            r_or = ($urandom_range(4) > 1);
            r_fl = ($urandom_range(63) == 0);
            r_pn = ($urandom_range(127) == 0);
            drive(r_iv, next_pc, r_or, r_fl, r_pn);
        end
        check("rnd wr_wraps_over_100", 32'(wr_wraps > 100), 32'd1);
        check("rnd rd_wraps_over_100", 32'(rd_wraps > 100), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_m_if_id_buffer

// File: doc/m_if_id_buffer.md
# m_if_id_buffer

Two-entry decoupling buffer between the fetch stage and the decode stage. It captures each fetched {PC, instruction} pair, presents the oldest pair to decode with a valid/ready handshake, and back-pressures fetch when full. It discards all in-flight entries on a taken branch/jump flush or on panic, so that decode never consumes wrong-path instructions.

## Interface
Parameters:
- DEPTH, 2: number of entries; power of two, at least 2.
- NOP, 32'h0000_0013: instruction word driven on instruction_out while empty.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  fetch presents a valid pair this cycle.
- pc_in  in  32  PC of the fetched instruction.
- instruction_in  in  32  fetched instruction word.
- in_ready  out  1  buffer accepts a pair this cycle; fetch holds its PC when low.
- out_valid  out  1  head entry is valid.
- pc_out  out  32  PC of the head entry.
- instruction_out  out  32  instruction of the head entry.
- out_ready  in  1  decode consumes the head entry this cycle.
- flush  in  1  a branch or jump resolved taken; all buffered entries are wrong-path.
- panic  in  1  fatal condition; flush, and refuse input while high.
- occupancy  out  2  number of valid entries, from 0 to DEPTH.

## Operation
- Storage is a circular array of DEPTH entries, each {pc[31:0], instr[31:0]}. It is addressed by the wr_ptr and rd_ptr pointers, each log2(DEPTH) bits, which wrap modulo DEPTH. A count register holds values from 0 to DEPTH.
- Enqueue condition: enq = in_valid & in_ready. Dequeue condition: deq = out_valid & out_ready.
- in_ready = (count < DEPTH) & ~panic & ~flush. It depends only on registered state and on flush/panic, with no combinational path from out_ready. A full buffer therefore refuses input even in a cycle where it dequeues.
- out_valid = (count != 0).
- pc_out and instruction_out come from the entry at rd_ptr. When empty they are 32'h0 and NOP respectively.
- occupancy = count.
- Priority, highest first:
  - reset: all state cleared.
  - flush or panic: count, wr_ptr and rd_ptr are set to 0. Any enqueue or dequeue in that cycle is ignored, and the incoming pair is dropped.
  - Normal operation: on enq, write at wr_ptr and increment wr_ptr. On deq, increment rd_ptr. count changes by +1, -1, or 0 when both occur.
- Simultaneous enq and deq at count = 1: count stays 1. The new entry becomes head in the following cycle.
- While panic is held high, the buffer stays empty and in_ready stays 0. Normal operation resumes the cycle after panic falls.
- Storage contents are not cleared on flush. Only the pointers and count are reset; stale data is never visible because out_valid is 0.
- Assertion: enq is never true when count == DEPTH. Bench checkers flag any overflow or underflow.

## Timing
- Reset values: out_valid = 0, pc_out = 0, instruction_out = NOP, occupancy = 0, and in_ready = 1 (provided panic and flush are low).
- Latency: a pair accepted at edge N appears on the outputs, with out_valid = 1, after edge N, i.e. in cycle N+1. There is no same-cycle bypass.
- Throughput: 1 pair per cycle sustained when decode holds out_ready = 1.
- A flush asserted in cycle N gives out_valid = 0 from cycle N+1. The earliest new accept is in cycle N+1, when flush is low.
- Reset asserted mid-operation clears state asynchronously, without waiting for a clock edge. Deassertion is released on the clock by the top-level synchronizer.

## Structure
- Shared package m_pipeline_pkg holds:
  - the NOP constant;
  - the XLEN = 32 width constant;
  - a fetch-packet typedef {pc, instr} that is reused by the ID stage.
- One sub-module: m_fifo_ctrl, which holds the pointers, count, full/empty logic and flush clear. The storage array and output mux stay in m_if_id_buffer.

## Test plan
- Reset, then stream in PC 0x0, 0x4, 0x8 on consecutive cycles with out_ready = 1. Required: outputs show 0x0, 0x4, 0x8 starting one cycle after each accept; occupancy stays 1.
- With out_ready = 0, offer 3 pairs. Required: the first 2 are accepted; in_ready = 0 and occupancy = 2 on the third. After raising out_ready, 0x0 is dequeued first, and the third pair is accepted one cycle later.
- With occupancy = 2, assert flush for 1 cycle while in_valid = 1. Required: the next cycle shows occupancy = 0, out_valid = 0, instruction_out = NOP, and the offered pair never appears.
- Hold panic high for 4 cycles with in_valid = 1. Required: in_ready = 0 and out_valid = 0 throughout; a pair offered the cycle after panic falls is accepted.
- Assert reset asynchronously between edges with occupancy = 1. Required: out_valid falls immediately, before the next clock edge, and occupancy = 0.
- Random in_valid/out_ready for 10k cycles against a queue model. Required: order is preserved, with no loss or duplication, and wrap-around of both pointers is exercised more than 100 times.
